tdc_frame_sink: RTL



---
 rtl/tdc_sink_pkg.sv | 24 ++
 rtl/tdc_frame_fifo.sv | 68 ++++++
 rtl/tdc_frame_sink.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tdc_sink_pkg.sv
// Shared types and constants for the TDC frame sink: FSM states, the packed
// frame-summary record and its fixed field widths.
package tdc_sink_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHECK   = 2'd2,
        DROP    = 2'd3
    } sink_state_t;

    localparam int          MAX_HITS   = 4;
    localparam logic [14:0] DEPTH_INIT = 15'h7FFF;
    localparam int          REC_W      = 30;

    // Field order is the readout order, MSB first.
    typedef struct packed {
        logic [2:0]  hit_cnt;
        logic [14:0] min_depth;
        logic [6:0]  sum_int;
        logic [4:0]  max_int;
    } frame_rec_t;

endpackage

// File: rtl/tdc_frame_fifo.sv
// Show-ahead frame-summary FIFO: the head entry is visible on pop_data whenever
// the FIFO is not empty; a pop while full lets a same-cycle push through.
module tdc_frame_fifo #(
    parameter int W     = 30,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int           AW       = $clog2(DEPTH);
    localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (count_r == {(AW + 1){1'b0}});
    assign full      = (count_r == FULL_CNT);
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Storage array, written at the tail on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head entry; forced to zero when there is nothing to show.
    always_comb begin
        if (empty) begin
            pop_data = {W{1'b0}};
        end else begin
            pop_data = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/tdc_frame_sink.sv
// TDC hit-stream consumer: checks frame framing, builds a per-frame summary
// (hit count, nearest depth, intensity sum and peak) and queues it for readout.
module tdc_frame_sink
    import tdc_sink_pkg::*;
#(
    parameter int DW          = 15,
    parameter int IW          = 5,
    parameter int FRAME_DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [DW-1:0]    s_data,
    input  logic [IW-1:0]    s_int,
    input  logic [1:0]       s_num,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    cfg_range,
    input  logic             irq_en,
    input  logic             err_clr,
    input  logic             rd_en,
    output logic [REC_W-1:0] rd_data,
    output logic             rd_empty,
    output logic [15:0]      frame_cnt,
    output logic [7:0]       ovr_cnt,
    output logic             err_len,
    output logic             irq
);
    localparam int SUM_W = IW + 2;

    sink_state_t      state_r;
    sink_state_t      state_nxt_s;
    logic             alive_r;
    logic [2:0]       beats_r;
    logic [1:0]       exp_num_r;
    logic [2:0]       hit_cnt_r;
    logic [DW-1:0]    min_r;
    logic [SUM_W-1:0] sum_r;
    logic [IW-1:0]    max_r;
    logic [15:0]      frame_cnt_r;
    logic [7:0]       ovr_cnt_r;
    logic             err_len_r;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             hs_s;
    logic             acc_en_s;
    logic             in_range_s;
    logic             len_ok_s;
    logic             push_s;
    logic             err_set_s;
    frame_rec_t       rec_s;

    assign hs_s       = s_valid & s_ready;
    assign acc_en_s   = hs_s & ((state_r == IDLE) | (state_r == COLLECT));
    assign in_range_s = (s_data <= cfg_range);
    assign len_ok_s   = (beats_r == ({1'b0, exp_num_r} + 3'd1));
    assign push_s     = (state_r == CHECK) & len_ok_s;
    // A 5th beat with no s_last is caught immediately; a 5th beat carrying
    // s_last reaches CHECK with 5 beats and fails the length compare there.
    assign err_set_s  = (acc_en_s & (state_r == COLLECT) & ~s_last & (beats_r == 3'(MAX_HITS)))
                      | ((state_r == CHECK) & ~len_ok_s);

    assign rec_s.hit_cnt   = hit_cnt_r;
    assign rec_s.min_depth = min_r;
    assign rec_s.sum_int   = sum_r;
    assign rec_s.max_int   = max_r;

    assign rd_empty  = fifo_empty_s;
    assign irq       = irq_en & ~fifo_empty_s;
    assign frame_cnt = frame_cnt_r;
    assign ovr_cnt   = ovr_cnt_r;
    assign err_len   = err_len_r;

    // Beat acceptance; alive_r keeps s_ready low through reset and the first cycle after.
    always_comb begin
        s_ready = 1'b0;
        case (state_r)
            IDLE, COLLECT: s_ready = alive_r & ~fifo_full_s;
            DROP:          s_ready = alive_r;
            default:       s_ready = 1'b0;
        endcase
    end

    // Frame FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (acc_en_s) begin
                    state_nxt_s = s_last ? CHECK : COLLECT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            COLLECT: begin
                if (acc_en_s && s_last) begin
                    state_nxt_s = CHECK;
                end else if (acc_en_s && (beats_r == 3'(MAX_HITS))) begin
                    state_nxt_s = DROP;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            CHECK: state_nxt_s = IDLE;
            DROP: begin
                if (hs_s && s_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DROP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register and post-reset ready enable.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            alive_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            alive_r <= 1'b1;
        end
    end

    // Per-frame accumulators; re-initialised while checking or dropping.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            beats_r   <= 3'd0;
            exp_num_r <= 2'd0;
            hit_cnt_r <= 3'd0;
            min_r     <= DEPTH_INIT;
            sum_r     <= {SUM_W{1'b0}};
            max_r     <= {IW{1'b0}};
        end else if ((state_r == CHECK) || (state_r == DROP)) begin
            beats_r   <= 3'd0;
            hit_cnt_r <= 3'd0;
            min_r     <= DEPTH_INIT;
            sum_r     <= {SUM_W{1'b0}};
            max_r     <= {IW{1'b0}};
        end else if (acc_en_s) begin
            beats_r <= beats_r + 3'd1;
            if (state_r == IDLE) begin
                exp_num_r <= s_num;
            end
            if (in_range_s) begin
                hit_cnt_r <= hit_cnt_r + 3'd1;
                sum_r     <= sum_r + SUM_W'(s_int);
                if (s_data < min_r) begin
                    min_r <= s_data;
                end
                if (s_int > max_r) begin
                    max_r <= s_int;
                end
            end
        end
    end

    // Frame / out-of-range counters and the sticky length error.
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= 16'd0;
            ovr_cnt_r   <= 8'd0;
            err_len_r   <= 1'b0;
        end else begin
            if (push_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end
            if (acc_en_s && !in_range_s && (ovr_cnt_r != 8'hFF)) begin
                ovr_cnt_r <= ovr_cnt_r + 8'd1;
            end
            if (err_set_s) begin
                err_len_r <= 1'b1;
            end else if (err_clr) begin
                err_len_r <= 1'b0;
            end
        end
    end

    tdc_frame_fifo #(
        .W     (REC_W),
        .DEPTH (FRAME_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst       (rst),
        .push      (push_s),
        .push_data (rec_s),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule
